divider_sequencer: RTL

Handshake front-end for the radix-4 SRT divider. Accepts one divide request per valid/ready transfer and drives the divider's `rst`/`start`/operand pins. Holds the operands stable for the whole computation, captures `q`/`r`/`divByZeroEx` on `done`, and presents them on a valid/ready result port. It sits directly upstream of the divider: between the execution-unit issue logic and the divider core.

---
 rtl/div_seq_pkg.sv | 25 ++
 rtl/div_watchdog.sv | 37 +++
 rtl/divider_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and timing helpers for the divider handshake sequencer.
package div_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        WAIT,
        RESP
    } DivSeqState;

    // Request handshake to outValid when the divider takes its fast path.
    localparam int FAST_LATENCY = 5;

    // Cycles spent in WAIT before the watchdog gives up on divDone.
    function automatic int watchdog_limit(input int n);
        return (n + 1) / 2 + 8;
    endfunction

    // Request handshake to outValid for a full-length divide.
    function automatic int latency(input int n);
        return (n + 1) / 2 + 6;
    endfunction

endpackage

// File: rtl/div_watchdog.sv
// Cycle counter that flags expiry after LIMIT enabled cycles; cleared whenever clear is high.
module div_watchdog #(
    parameter int LIMIT = 24
) (
    input  logic clk,
    input  logic rstN,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Expiry is reported in the LIMIT-th enabled cycle so the caller leaves on that edge.
    assign expired = enable && (count_q == CNT_W'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/divider_sequencer.sv
// Valid/ready front-end for the radix-4 SRT divider: clears, starts and holds the core, then returns its result.
// Optional DIV_SEQ_WATCHDOG_EN adds a WAIT timeout that returns an error result instead of hanging.
module divider_sequencer
    import div_seq_pkg::*;
#(
    parameter int N     = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic             inSigned,
    input  logic [N-1:0]     inX,
    input  logic [N-1:0]     inY,
    input  logic [TAG_W-1:0] inTag,
    output logic             outValid,
    input  logic             outReady,
    output logic [N-1:0]     outQ,
    output logic [N-1:0]     outR,
    output logic [TAG_W-1:0] outTag,
    output logic             outDivByZero,
    output logic             outError,
    output logic             divRst,
    output logic             divStart,
    output logic             divSigned,
    output logic [N-1:0]     divX,
    output logic [N-1:0]     divY,
    input  logic [N-1:0]     divQ,
    input  logic [N-1:0]     divR,
    input  logic             divDone,
    input  logic             divDivByZero
);

    DivSeqState       state_q, state_d;
    logic             sgn_q, sgn_d;
    logic [N-1:0]     x_q, x_d;
    logic [N-1:0]     y_q, y_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [N-1:0]     quot_q, quot_d;
    logic [N-1:0]     rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             err_q, err_d;
    logic             wd_expired;

`ifdef DIV_SEQ_WATCHDOG_EN
    div_watchdog #(
        .LIMIT (watchdog_limit(N))
    ) u_watchdog (
        .clk     (clk),
        .rstN    (rstN),
        .clear   (state_q != WAIT),
        .enable  (state_q == WAIT),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        x_d     = x_q;
        y_d     = y_q;
        tag_d   = tag_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    sgn_d   = inSigned;
                    x_d     = inX;
                    y_d     = inY;
                    tag_d   = inTag;
                    state_d = CLEAR;
                end
            end
            CLEAR: state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                // A real completion wins over a watchdog expiry in the same cycle.
                if (divDone) begin
                    quot_d  = divQ;
                    rem_d   = divR;
                    dbz_d   = divDivByZero;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wd_expired) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            sgn_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            tag_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tag_q   <= tag_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            err_q   <= err_d;
        end
    end

    assign inReady      = (state_q == IDLE);
    assign outValid     = (state_q == RESP);
    assign outQ         = quot_q;
    assign outR         = rem_q;
    assign outTag       = tag_q;
    assign outDivByZero = dbz_q;
    assign outError     = err_q;

    // The core parks in DONE after every divide, so it is reset before each new one.
    assign divRst    = !rstN || (state_q == CLEAR);
    assign divStart  = (state_q == ISSUE);
    assign divSigned = sgn_q;
    assign divX      = x_q;
    assign divY      = y_q;

endmodule
